// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and iteration count for the sequential multiplier
package mult_pkg;

   // Controller states: waiting, iterating, result-valid pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   // One shift-add iteration per multiplier bit
   localparam int MULT_ITERS = 64;

endpackage

// File: rtl/cla64.sv
// rtl/cla64.sv - 64-bit carry-lookahead adder built from 4-bit lookahead groups
module cla64 (
   input  logic [63:0] a,
   input  logic [63:0] b,
   input  logic        cIn,
   output logic [63:0] s,
   output logic        cOut,
   output logic        pg,
   output logic        gg
);

   logic [63:0] g;
   logic [63:0] p;
   logic [63:0] c;
   logic [15:0] grpG;
   logic [15:0] grpP;
   logic [16:0] grpC;
   logic        ggAcc;

   // Bit generate/propagate, per-group lookahead, group carry chain, then in-group carries
   always_comb begin
      g     = a & b;
      p     = a ^ b;
      c     = '0;
      grpG  = '0;
      grpP  = '0;
      grpC  = '0;
      ggAcc = 1'b0;
      grpC[0] = cIn;
      for (int i = 0; i < 16; i++) begin
         grpG[i] = g[4*i+3]
                 | (p[4*i+3] & g[4*i+2])
                 | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                 | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
         grpP[i] = &p[4*i +: 4];
         grpC[i+1] = grpG[i] | (grpP[i] & grpC[i]);
         ggAcc = grpG[i] | (grpP[i] & ggAcc);
         c[4*i] = grpC[i];
         for (int j = 0; j < 3; j++) begin
            c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
         end
      end
      s    = p ^ c;
      cOut = grpC[16];
      pg   = &grpP;
      gg   = ggAcc;
   end

endmodule

// File: rtl/mult64_seq.sv
// rtl/mult64_seq.sv - iterative 64x64->128 shift-add multiplier (optional MULT_ZERO_SKIP_EN)
module mult64_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   mult_state_t      state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [CNT_W-1:0] count;

   logic [WIDTH-1:0] addB;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             unusedPg;
   logic             unusedGg;

   // Addend is the multiplicand only when the current multiplier bit is set
   always_comb begin
      addB = mq[0] ? mcand : '0;
   end

   cla64 adder (
      .a    (acc),
      .b    (addB),
      .cIn  (1'b0),
      .s    (sum),
      .cOut (carry),
      .pg   (unusedPg),
      .gg   (unusedGg)
   );

   // The accumulator and the multiplier register form one 128-bit shift register
   assign product = {acc, mq};

   // Controller, counter and datapath registers with registered busy/done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         mcand <= '0;
         acc   <= '0;
         mq    <= '0;
         count <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mcand <= multiplicand;
                  acc   <= '0;
                  mq    <= multiplier;
                  count <= '0;
`ifdef MULT_ZERO_SKIP_EN
                  if ((multiplicand == '0) || (multiplier == '0)) begin
                     // Product is known to be zero; present it without iterating
                     mq    <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
`else
                  state <= RUN;
                  busy  <= 1'b1;
                  done  <= 1'b0;
`endif
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            RUN: begin
               // Carry-out becomes the top bit of the shifted accumulator
               {acc, mq} <= {carry, sum, mq[WIDTH-1:1]};
               count     <= count + CNT_W'(1);
               if (count == CNT_W'(MULT_ITERS - 1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
